// File: rtl/cic_decimator.sv
// ---------------------------------------------------------------------------
// cic_decimator
//   Three-stage CIC decimator (differential delay 1, decimation R = 2^SET_DEC_LOG2)
//   for a signed mixer product. Integrators run at the input sample rate and
//   advance only on valid_i. Combs run once per decimated sample as a
//   one-register-per-stage pipeline. The top SET_OUT_WIDTH bits of the W-bit
//   comb result are clipped to the output range.
//
//   Optional build macro: CIC_ROUND_EN
//     defined   -> add 2^(W-SET_OUT_WIDTH-1) before truncation (round half up)
//     undefined -> plain truncation toward negative infinity, no adder
//
// Ports
//   clk_i    in   1              clock
//   rst_n_i  in   1              asynchronous active-low reset
//   clr_i    in   1              synchronous clear of all filter state
//   valid_i  in   1              input sample strobe
//   data_i   in   SET_IN_WIDTH   signed mixer product
//   valid_o  out  1              one-cycle pulse per decimated sample
//   data_o   out  SET_OUT_WIDTH  signed decimated sample (held between pulses)
//   sat_o    out  1              sticky saturation flag
// ---------------------------------------------------------------------------
module cic_decimator #(
  parameter int SET_IN_WIDTH  = 23,
  parameter int SET_DEC_LOG2  = 4,
  parameter int SET_OUT_WIDTH = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            clr_i,
  input  logic                            valid_i,
  input  logic signed [SET_IN_WIDTH-1:0]  data_i,
  output logic                            valid_o,
  output logic signed [SET_OUT_WIDTH-1:0] data_o,
  output logic                            sat_o
);

  localparam int W  = SET_IN_WIDTH + 3 * SET_DEC_LOG2;
  localparam int SH = W - SET_OUT_WIDTH;

  localparam logic signed [SET_OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(SET_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SET_OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(SET_OUT_WIDTH-1){1'b0}}};

`ifdef CIC_ROUND_EN
  localparam logic [W:0] RND = {{(W-SH+1){1'b0}}, 1'b1, {(SH-1){1'b0}}};
`endif

  logic signed [W-1:0]          integ1, integ2, integ3;
  logic signed [W-1:0]          i1_nxt, i2_nxt, i3_nxt;
  logic signed [W-1:0]          c1, c2, c3;
  logic signed [W-1:0]          d1, d2, d3;
  logic [SET_DEC_LOG2-1:0]      cnt;
  logic                         dec_v, v1, v2, v3;
  logic [W:0]                   ext;
  logic [SET_OUT_WIDTH:0]       qv;
  logic                         clip;
  logic signed [SET_OUT_WIDTH-1:0] q_sat;

  // Integrator cascade for the current sample; the three adders are chained
  // so the registered state always equals the ideal CIC integrator outputs.
  always_comb begin
    i1_nxt = integ1 + {{(W-SET_IN_WIDTH){data_i[SET_IN_WIDTH-1]}}, data_i};
    i2_nxt = integ2 + i1_nxt;
    i3_nxt = integ3 + i2_nxt;
  end

  // Output quantiser: one guard bit above the comb result catches the carry
  // out of the rounding constant, so overflow shows up as a sign mismatch
  // between the guard bit and the output MSB.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ext   = '0;
    q_sat = '0;
`ifdef CIC_ROUND_EN
    ext = {c3[W-1], c3} + RND;
`else
    ext = {c3[W-1], c3};
`endif
    qv   = ext[W:SH];
    clip = qv[SET_OUT_WIDTH] ^ qv[SET_OUT_WIDTH-1];
    if (clip) q_sat = qv[SET_OUT_WIDTH] ? OUT_MIN : OUT_MAX;
    else      q_sat = qv[SET_OUT_WIDTH-1:0];
  end

  // Pipeline timing for a triggering sample accepted at edge E0:
  //   E0 integrators + dec_v, E1 comb1, E2 comb2, E3 comb3, E4 valid_o/data_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) begin
      integ1 <= '0; integ2 <= '0; integ3 <= '0;
      c1 <= '0; c2 <= '0; c3 <= '0;
      d1 <= '0; d2 <= '0; d3 <= '0;
      cnt <= '0;
      dec_v <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      valid_o <= 1'b0; data_o <= '0; sat_o <= 1'b0;
    end else if (clr_i) begin
      integ1 <= '0; integ2 <= '0; integ3 <= '0;
      c1 <= '0; c2 <= '0; c3 <= '0;
      d1 <= '0; d2 <= '0; d3 <= '0;
      cnt <= '0;
      dec_v <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      valid_o <= 1'b0; data_o <= '0; sat_o <= 1'b0;
    end else begin
      if (valid_i) begin
        integ1 <= i1_nxt;
        integ2 <= i2_nxt;
        integ3 <= i3_nxt;
        cnt    <= cnt + SET_DEC_LOG2'(1);
      end
      dec_v <= valid_i && (cnt == '1);

      v1 <= dec_v;
      if (dec_v) begin
        c1 <= integ3 - d1;
        d1 <= integ3;
      end

      v2 <= v1;
      if (v1) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end

      v3 <= v2;
      if (v2) begin
        c3 <= c2 - d3;
        d3 <= c2;
      end

      valid_o <= v3;
      if (v3) begin
        data_o <= q_sat;
        sat_o  <= sat_o | clip;
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_cic_decimator
//   Self-checking bench for cic_decimator at default parameters. The reference
//   model keeps the full history of accepted samples and evaluates each
//   decimated output as a direct convolution with the 3-stage CIC impulse
//   response, then quantises it (rounding when CIC_ROUND_EN is defined).
// ---------------------------------------------------------------------------
module tb_cic_decimator;

  localparam int IN  = 23;
  localparam int L   = 4;
  localparam int OUT = 16;
  localparam int R   = 1 << L;
  localparam int W   = IN + 3 * L;
  localparam int SH  = W - OUT;
  localparam int HL  = 3 * R - 2;

  typedef struct {
    longint due;
    longint val;
    bit     sat;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  clr = 1'b0;
  logic                  vin = 1'b0;
  logic signed [IN-1:0]  din = '0;
  logic                  valid_o;
  logic signed [OUT-1:0] data_o;
  logic                  sat_o;

  cic_decimator #(
    .SET_IN_WIDTH (IN),
    .SET_DEC_LOG2 (L),
    .SET_OUT_WIDTH(OUT)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .clr_i  (clr),
    .valid_i(vin),
    .data_i (din),
    .valid_o(valid_o),
    .data_o (data_o),
    .sat_o  (sat_o)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  longint hcoef[HL];
  longint xs[$];
  exp_t   exp_q[$];
  longint last_val = 0;
  bit     last_sat = 1'b0;
  int     n_out = 0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  // Ideal CIC output from the accepted-sample history, then quantised.
  task automatic model_out(output longint v, output bit s);
    longint y;
    longint q;
    int     n;
    y = 0;
    n = xs.size();
    for (int j = 0; j < HL; j++)
      if (n - 1 - j >= 0) y += hcoef[j] * xs[n-1-j];
`ifdef CIC_ROUND_EN
    y += longint'(1) << (SH - 1);
`endif
    q = y >>> SH;
    s = 1'b0;
    if (q > 32767)       begin q = 32767;  s = 1'b1; end
    else if (q < -32768) begin q = -32768; s = 1'b1; end
    v = q;
  endtask

  task automatic model_clear();
    xs.delete();
    exp_q.delete();
    last_val = 0;
    last_sat = 1'b0;
    n_out    = 0;
  endtask

  // One clock: drive inputs, update the model for that edge, check outputs.
  task automatic tick(input bit v, input longint d, input bit c);
    exp_t e;
    bit   due;
    vin = v;
    din = d[IN-1:0];
    clr = c;
    @(posedge clk);
    #1;
    cyc++;
    if (c) model_clear();
    else if (v) begin
      xs.push_back(d);
      if (xs.size() % R == 0) begin
        model_out(e.val, e.sat);
        e.due = cyc + 4;
        exp_q.push_back(e);
      end
    end
    due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (due) begin
      e = exp_q.pop_front();
      last_val = e.val;
      last_sat = last_sat | e.sat;
      n_out++;
    end
    chk("valid_o", longint'(valid_o), longint'(due));
    chk("data_o", longint'(data_o), last_val);
    chk("sat_o", longint'(sat_o), longint'(last_sat));
    vin = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0);
  endtask

  task automatic dc_run(input longint d, input int nsamp, input int gap);
    for (int i = 0; i < nsamp; i++) begin
      tick(1'b1, d, 1'b0);
      for (int g = 1; g < gap; g++) tick(1'b0, d, 1'b0);
    end
  endtask

  logic signed [IN-1:0] rnd_s;
  longint               rnd_l;

  initial begin
    for (int j = 0; j < HL; j++) hcoef[j] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          hcoef[a+b+c] += 1;

    // Reset state
    rst_n = 1'b0;
    #12;
    chk("rst_valid", longint'(valid_o), 0);
    chk("rst_data", longint'(data_o), 0);
    chk("rst_sat", longint'(sat_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    idle(3);

    // DC 12800, valid every cycle -> settles to 100
    dc_run(12800, 16 * 5, 1);
    idle(6);
    chk("dc12800_outputs", n_out, 5);
    chk("dc12800_value", longint'(data_o), 100);

    // DC 12864 -> 101 with rounding, 100 without
    tick(1'b1, 12864, 1'b1);
    dc_run(12864, 16 * 4, 1);
    idle(6);
`ifdef CIC_ROUND_EN
    chk("dc12864_value", longint'(data_o), 101);
`else
    chk("dc12864_value", longint'(data_o), 100);
`endif

    // DC 12800, valid every third cycle
    tick(1'b0, 0, 1'b1);
    dc_run(12800, 16 * 4, 3);
    idle(6);
    chk("gap_outputs", n_out, 4);
    chk("gap_value", longint'(data_o), 100);

    // Reset after 10 of 16 samples
    tick(1'b0, 0, 1'b1);
    dc_run(12800, 16 * 2, 1);
    idle(6);
    dc_run(12800, 10, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", longint'(valid_o), 0);
    chk("midrst_data", longint'(data_o), 0);
    chk("midrst_sat", longint'(sat_o), 0);
    model_clear();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    dc_run(12800, 15, 1);
    idle(6);
    chk("midrst_no_early", n_out, 0);
    dc_run(12800, 1, 1);
    idle(6);
    chk("midrst_after16", n_out, 1);

    // Full-scale DC -> saturation with rounding
    tick(1'b0, 0, 1'b1);
    dc_run(4194303, 16 * 4, 1);
    idle(10);
    chk("fs_value", longint'(data_o), 32767);
`ifdef CIC_ROUND_EN
    chk("fs_sat", longint'(sat_o), 1);
`else
    chk("fs_sat", longint'(sat_o), 0);
`endif
    tick(1'b1, 4194303, 1'b1);
    chk("clr_sat", longint'(sat_o), 0);
    chk("clr_data", longint'(data_o), 0);
    idle(6);

    // Random data, random valid pattern
    for (int i = 0; i < 4096; i++) begin
      rnd_s = IN'($urandom);
      rnd_l = rnd_s;
      while ($urandom_range(3) == 0) tick(1'b0, rnd_l, 1'b0);
      tick(1'b1, rnd_l, 1'b0);
    end
    idle(8);
    chk("rand_outputs", n_out, 4096 / R);
    chk("rand_drained", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
